multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised successor to the team's multicycle MIPS main controller. It sequences fetch, decode, execute, memory and writeback for the subset R-type, jr, addi/addiu, andi, ori, slti, lui, beq, bne, j, jal, lw and sw. Unlike the previous controller, it stalls on a memory-ready handshake, times out hung memory accesses, drives every output to a defined value in every state and traps illegal opcodes. It sits in the control unit between the instruction register and the datapath muxes and enables.

## Interface
- ALUOP_W, 3: ALUOp width, minimum 3.
- TIMEOUT_CYCLES, 16: maximum wait cycles per memory access; 0 disables the timeout.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access in progress
- IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch, BranchNe  out  1 each  datapath controls; Ori selects zero-extension
- ALUSrcB, PCSrc, MemtoReg, RegDst  out  2 each  datapath mux selects
- ALUOp  out  ALUOP_W  0 add, 1 sub, 2 decode funct, 3 or, 4 slt, 5 and, 6 lui
- mem_timeout  out  1  one-cycle pulse when an access is aborted
- illegal  out  1  sticky flag, trap taken
- state  out  5  debug view of the current state

## Operation
- Outputs decode combinationally from `state` (Moore). Only IRWrite, PCWrite, MemWrite and mem_timeout also depend on mem_ready or the wait counter.
- No output is ever X. Any signal not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC 6, ALUWB 7, IMMEX 8, IMMWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, TRAP 14.
- FETCH: mem_req=1, ALUSrcB=01, ALUOp=0. IRWrite=PCWrite=mem_ready. Goes to DECODE on mem_ready, otherwise stays.
- DECODE: ALUSrcB=11, ALUOp=0. Dispatch:
  - Opcode 0 with funct 0x08 → JR; any other Opcode 0 → EXEC.
  - 0x23/0x2b → MEMADR; 0x08, 0x09, 0x0a, 0x0c, 0x0d, 0x0f → IMMEX.
  - 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x03 → JAL.
  - Any other opcode → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Goes to FETCH.
- MEMWRITE: mem_req=1, IorD=1, MemWrite=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=2. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=01. Goes to FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp and Ori by opcode: addi/addiu 0; slti 4; andi 5 with Ori=1; ori 3 with Ori=1; lui 6 with Ori=1. Goes to IMMWB.
- IMMWB: RegWrite=1, RegDst=00, MemtoReg=00. ALUOp and Ori stay as in IMMEX. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=1, PCSrc=01. Branch=1 for beq, BranchNe=1 for bne. Goes to FETCH.
- JUMP: PCWrite=1, PCSrc=10. Goes to FETCH.
- JAL: as JUMP plus RegWrite=1, RegDst=10, MemtoReg=10. Goes to FETCH.
- JR: PCWrite=1, PCSrc=11. Goes to FETCH.
- Wait counter, width clog2(TIMEOUT_CYCLES)+1:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE, and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When counter == TIMEOUT_CYCLES-1 and mem_ready=0: mem_timeout=1, IRWrite/PCWrite/MemWrite are forced to 0, and next state is FETCH.
- mem_ready on the same cycle as the timeout condition wins; no timeout is raised.
- mem_ready outside the wait states is ignored.

## Timing
- Reset (async assert): state=FETCH, counter=0, illegal=0. Outputs then take their FETCH values: mem_req=1, ALUSrcB=01, everything else 0.
- Reset mid-access aborts immediately; no write strobes are driven after rst rises.
- Cycles per instruction with zero-wait memory: R-type/immediate 4, lw 5, sw 4, branch/j/jal/jr 3. Each wait cycle adds 1.
- Opcode and funct are sampled only in DECODE, MEMADR, IMMEX, IMMWB, BRANCH and EXEC. They must be stable from IRWrite until the next FETCH.

## Configuration
- MCTRL_ILLEGAL_TRAP_EN defined: illegal opcode → TRAP. TRAP holds all controls at 0, illegal=1, and the block stays there until rst.
- Undefined: illegal opcode → FETCH (executes as a NOP). illegal is tied to 0 and TRAP is unreachable.

## Test plan
- Reset with mem_ready=1, then fetch of add (0x00/0x20) → states 0,1,6,7,0. RegWrite=1 and RegDst=01 only in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD → 8 cycles total. MemtoReg=01 and RegWrite=1 in MEMWB.
- TIMEOUT_CYCLES=4, mem_ready held 0 in MEMWRITE → MemWrite high 3 cycles, mem_timeout pulses in the 4th with MemWrite=0, then state=0.
- bne (0x05) → BranchNe=1, Branch=0, ALUOp=1, PCSrc=01. jal (0x03) → PCWrite=1, RegDst=10, MemtoReg=10.
- Opcode 0x3f with the macro defined → state=14, illegal=1, held for 20 cycles until rst. Without the macro → back to FETCH, illegal=0.
- rst pulse in MEMWRITE while waiting → MemWrite drops asynchronously and state=0 on deassertion.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS main controller (Moore FSM) with a
// memory-ready handshake, a per-access wait timeout and an optional illegal-
// opcode trap. Defining MCTRL_ILLEGAL_TRAP_EN sends illegal opcodes to a
// sticky TRAP state; otherwise they retire as a NOP through FETCH.
module multicycle_ctrl #(
    parameter int unsigned ALUOP_W        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               Ori,
    output logic               Branch,
    output logic               BranchNe,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               mem_timeout,
    output logic               illegal,
    output logic [4:0]         state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [4:0] S_FETCH    = 5'd0;
    localparam logic [4:0] S_DECODE   = 5'd1;
    localparam logic [4:0] S_MEMADR   = 5'd2;
    localparam logic [4:0] S_MEMREAD  = 5'd3;
    localparam logic [4:0] S_MEMWB    = 5'd4;
    localparam logic [4:0] S_MEMWRITE = 5'd5;
    localparam logic [4:0] S_EXEC     = 5'd6;
    localparam logic [4:0] S_ALUWB    = 5'd7;
    localparam logic [4:0] S_IMMEX    = 5'd8;
    localparam logic [4:0] S_IMMWB    = 5'd9;
    localparam logic [4:0] S_BRANCH   = 5'd10;
    localparam logic [4:0] S_JUMP     = 5'd11;
    localparam logic [4:0] S_JAL      = 5'd12;
    localparam logic [4:0] S_JR       = 5'd13;
    localparam logic [4:0] S_TRAP     = 5'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(6);

    logic [4:0]         r_state;
    logic [4:0]         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_wait;
    logic               w_tmo;
    logic [ALUOP_W-1:0] w_imm_aluop;
    logic               w_imm_ori;

    assign state  = r_state;
    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                    (r_state == S_MEMWRITE);

    // Timeout fires on the last allowed wait cycle unless memory answers then
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_tmo
            assign w_tmo = 1'b0;
        end else begin : g_tmo
            assign w_tmo = w_wait && !mem_ready &&
                           (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    // Counter runs only while stalled in a wait state; zero everywhere else
    assign w_cnt_next = (w_wait && !mem_ready && !w_tmo) ? r_cnt + CNT_W'(1)
                                                         : '0;

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Sticky trap flag, raised on entry to TRAP
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Immediate-class ALU operation and zero-extend select
    always_comb begin
        w_imm_aluop = ALU_ADD;
        w_imm_ori   = 1'b0;
        case (Opcode)
            OP_SLTI: w_imm_aluop = ALU_SLT;
            OP_ANDI: begin w_imm_aluop = ALU_AND; w_imm_ori = 1'b1; end
            OP_ORI:  begin w_imm_aluop = ALU_OR;  w_imm_ori = 1'b1; end
            OP_LUI:  begin w_imm_aluop = ALU_LUI; w_imm_ori = 1'b1; end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (w_tmo)          w_next = S_FETCH;
                else if (mem_ready) w_next = S_DECODE;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: w_next = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                        w_next = S_IMMEX;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:     w_next = S_JUMP;
                    OP_JAL:   w_next = S_JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:  w_next = S_TRAP;
`else
                    default:  w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (w_tmo)          w_next = S_FETCH;
                else if (mem_ready) w_next = S_MEMWB;
                else                w_next = S_MEMREAD;
            end
            S_MEMWRITE: w_next = (w_tmo || mem_ready) ? S_FETCH : S_MEMWRITE;
            S_EXEC:     w_next = S_ALUWB;
            S_IMMEX:    w_next = S_IMMWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore output decode; strobes additionally gated by handshake/timeout
    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        IRWrite     = 1'b0;
        MemWrite    = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        Ori         = 1'b0;
        Branch      = 1'b0;
        BranchNe    = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        MemtoReg    = 2'b00;
        RegDst      = 2'b00;
        ALUOp       = ALU_ADD;
        mem_timeout = w_tmo;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready && !w_tmo;
                PCWrite = mem_ready && !w_tmo;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = !w_tmo;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FN;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = w_imm_aluop;
                Ori     = w_imm_ori;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                ALUOp    = w_imm_aluop;
                Ori      = w_imm_ori;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSrc    = 2'b01;
                Branch   = (Opcode == OP_BEQ);
                BranchNe = (Opcode == OP_BNE);
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
            end
            S_TRAP:  ;
            default: ;
        endcase
    end

endmodule
